fb_arbiter: RTL and testbench

- Two-port arbiter sharing the single-pixel framebuffer port (x/y/read/write/in/out/rdy) between two requesters.
- Port 0 is the drawing engine (blit/fill/byte access); port 1 is the display scanout reader.
- Each requester sees an independent copy of the framebuffer pixel protocol. The arbiter serialises their accesses onto the memory side.
- Scanout has priority, with a bounded-run rule so drawing is never starved.

---
 rtl/fb_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_fb_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_arbiter.sv
// fb_arbiter: shares one single-pixel framebuffer port between the drawing
// engine (port 0) and the display scanout reader (port 1). Scanout wins ties,
// but only for SCAN_RUN grants in a row while drawing is waiting.
//
// Requester handshake (same on both ports): rdy_i high means the port is idle.
// A one-cycle read_i/write_i pulse is taken only on an edge where rdy_i is
// high; that edge latches x_i/y_i/in_i and the op and drops rdy_i. rdy_i rises
// again on the edge that completes the access, with out_i valid from then on
// for reads. Pulses seen while rdy_i is low are dropped; read+write is a write.
// The memory side follows the same protocol with the roles reversed.
module fb_arbiter #(
    parameter int SCAN_RUN = 4,
    parameter int XMAX     = 319,
    parameter int YMAX     = 199
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] x_0,
    input  logic [7:0] y_0,
    input  logic       read_0,
    input  logic       write_0,
    input  logic       in_0,
    output logic       out_0,
    output logic       rdy_0,
    input  logic [8:0] x_1,
    input  logic [7:0] y_1,
    input  logic       read_1,
    input  logic       write_1,
    input  logic       in_1,
    output logic       out_1,
    output logic       rdy_1,
    output logic [8:0] x_m,
    output logic [7:0] y_m,
    output logic       read_m,
    output logic       write_m,
    output logic       in_m,
    input  logic       out_m,
    input  logic       rdy_m,
    output logic       busy,
    output logic       owner
);

    localparam int              RUN_W   = (SCAN_RUN < 1) ? 1 : $clog2(SCAN_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(SCAN_RUN);
    localparam logic [8:0]      X_LIM   = 9'(XMAX);
    localparam logic [7:0]      Y_LIM   = 8'(YMAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Per-port request latches
    logic       pend_0, pend_1;
    logic       wr_0, wr_1;
    logic       d_0, d_1;
    logic [8:0] xl_0, xl_1;
    logic [7:0] yl_0, yl_1;

    logic [RUN_W-1:0] run_cnt;

    logic acc_0, acc_1;
    logic inr_0, inr_1;
    logic req_0, req_1;
    logic oor_0, oor_1;
    logic gnt, gnt_port, cpl;

    assign acc_0 = rdy_0 & (read_0 | write_0);
    assign acc_1 = rdy_1 & (read_1 | write_1);
    assign inr_0 = (xl_0 <= X_LIM) & (yl_0 <= Y_LIM);
    assign inr_1 = (xl_1 <= X_LIM) & (yl_1 <= Y_LIM);
    assign req_0 = pend_0 & inr_0;
    assign req_1 = pend_1 & inr_1;
    assign oor_0 = pend_0 & ~inr_0;
    assign oor_1 = pend_1 & ~inr_1;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: one ISSUE cycle per grant, then wait for memory ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (rdy_m) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/control decode: grant choice and completion strobe
    always_comb begin
        gnt      = 1'b0;
        gnt_port = 1'b0;
        cpl      = 1'b0;
        if (state_q == IDLE && rdy_m && (req_0 || req_1)) begin
            gnt = 1'b1;
            if (req_0 && req_1) gnt_port = (run_cnt < RUN_MAX);
            else                gnt_port = req_1;
        end
        if (state_q == WAIT && rdy_m) cpl = 1'b1;
    end

    // Port 0 request latch, ready flag and read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_0 <= 1'b0;
            rdy_0  <= 1'b1;
            out_0  <= 1'b0;
            wr_0   <= 1'b0;
            d_0    <= 1'b0;
            xl_0   <= '0;
            yl_0   <= '0;
        end else if (acc_0) begin
            pend_0 <= 1'b1;
            rdy_0  <= 1'b0;
            wr_0   <= write_0;
            d_0    <= in_0;
            xl_0   <= x_0;
            yl_0   <= y_0;
        end else if (oor_0) begin
            pend_0 <= 1'b0;
            rdy_0  <= 1'b1;
            out_0  <= 1'b0;
        end else if (cpl && !owner) begin
            pend_0 <= 1'b0;
            rdy_0  <= 1'b1;
            if (!wr_0) out_0 <= out_m;
        end
    end

    // Port 1 request latch, ready flag and read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_1 <= 1'b0;
            rdy_1  <= 1'b1;
            out_1  <= 1'b0;
            wr_1   <= 1'b0;
            d_1    <= 1'b0;
            xl_1   <= '0;
            yl_1   <= '0;
        end else if (acc_1) begin
            pend_1 <= 1'b1;
            rdy_1  <= 1'b0;
            wr_1   <= write_1;
            d_1    <= in_1;
            xl_1   <= x_1;
            yl_1   <= y_1;
        end else if (oor_1) begin
            pend_1 <= 1'b0;
            rdy_1  <= 1'b1;
            out_1  <= 1'b0;
        end else if (cpl && owner) begin
            pend_1 <= 1'b0;
            rdy_1  <= 1'b1;
            if (!wr_1) out_1 <= out_m;
        end
    end

    // Memory side: load operands on grant, drop the strobe after ISSUE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_m     <= '0;
            y_m     <= '0;
            in_m    <= 1'b0;
            read_m  <= 1'b0;
            write_m <= 1'b0;
            busy    <= 1'b0;
            owner   <= 1'b0;
        end else if (gnt) begin
            owner   <= gnt_port;
            busy    <= 1'b1;
            x_m     <= gnt_port ? xl_1 : xl_0;
            y_m     <= gnt_port ? yl_1 : yl_0;
            in_m    <= gnt_port ? d_1 : d_0;
            read_m  <= ~(gnt_port ? wr_1 : wr_0);
            write_m <= gnt_port ? wr_1 : wr_0;
        end else if (state_q == ISSUE) begin
            read_m  <= 1'b0;
            write_m <= 1'b0;
        end else if (cpl) begin
            busy    <= 1'b0;
        end
    end

    // Scanout run counter: counts contested port-1 wins, reset when drawing is served or idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt <= '0;
        end else if (!pend_0 || (gnt && !gnt_port)) begin
            run_cnt <= '0;
        end else if (gnt && req_0 && (run_cnt < RUN_MAX)) begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: directed checks of the two-port framebuffer arbiter against
// hand-computed cycle timing, with a small behavioural memory on the far side.
module tb_fb_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] x_0 = '0, x_1 = '0;
    logic [7:0] y_0 = '0, y_1 = '0;
    logic       read_0 = 1'b0, write_0 = 1'b0, in_0 = 1'b0;
    logic       read_1 = 1'b0, write_1 = 1'b0, in_1 = 1'b0;
    logic       out_0, rdy_0, out_1, rdy_1;
    logic [8:0] x_m;
    logic [7:0] y_m;
    logic       read_m, write_m, in_m, out_m, rdy_m, busy, owner;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model controls
    int   mem_lat     = 0;
    int   mem_rec     = 0;
    int   mem_cnt     = 0;
    bit   rec_pending = 1'b0;
    bit   rec_release = 1'b0;
    logic mem_rdy     = 1'b1;
    logic mem_hold    = 1'b0;
    logic mem_rdata   = 1'b0;

    // Log of every memory-side strobe
    logic       log_owner_q[$];
    logic       log_wr_q[$];
    logic [8:0] log_x_q[$];
    logic [0:0] exp_q[$];

    assign rdy_m = mem_rdy & ~mem_hold;
    assign out_m = mem_rdata;

    fb_arbiter dut (
        .clk(clk), .rst(rst),
        .x_0(x_0), .y_0(y_0), .read_0(read_0), .write_0(write_0), .in_0(in_0),
        .out_0(out_0), .rdy_0(rdy_0),
        .x_1(x_1), .y_1(y_1), .read_1(read_1), .write_1(write_1), .in_1(in_1),
        .out_1(out_1), .rdy_1(rdy_1),
        .x_m(x_m), .y_m(y_m), .read_m(read_m), .write_m(write_m), .in_m(in_m),
        .out_m(out_m), .rdy_m(rdy_m), .busy(busy), .owner(owner)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got running want done");
        $fatal(1);
    end

    // Memory: busy for mem_lat cycles after a strobe, optional recovery cycle after completing
    always @(negedge clk) begin
        if (read_m || write_m) begin
            log_owner_q.push_back(owner);
            log_wr_q.push_back(write_m);
            log_x_q.push_back(x_m);
        end
        if (rec_release) begin
            mem_rdy = 1'b1;
            rec_release = 1'b0;
        end else if (rec_pending) begin
            mem_rdy = 1'b0;
            rec_pending = 1'b0;
            rec_release = 1'b1;
        end else if (read_m || write_m) begin
            if (mem_lat > 0) begin
                mem_rdy = 1'b0;
                mem_cnt = mem_lat;
            end
        end else if (mem_cnt > 0) begin
            mem_cnt = mem_cnt - 1;
            if (mem_cnt == 0) begin
                mem_rdy = 1'b1;
                rec_pending = (mem_rec != 0);
            end
        end
    end

    // Driver tasks: call at a falling edge; the pulse is seen by exactly one rising edge
    task automatic req_0(input logic rd, input logic wr, input logic [8:0] x,
                         input logic [7:0] y, input logic d);
        read_0 = rd; write_0 = wr; x_0 = x; y_0 = y; in_0 = d;
        @(negedge clk);
        read_0 = 1'b0; write_0 = 1'b0;
    endtask

    task automatic req_1(input logic rd, input logic wr, input logic [8:0] x,
                         input logic [7:0] y, input logic d);
        read_1 = rd; write_1 = wr; x_1 = x; y_1 = y; in_1 = d;
        @(negedge clk);
        read_1 = 1'b0; write_1 = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (rdy_0 && rdy_1 && !busy) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({rdy_0, rdy_1, out_0, out_1, read_m, write_m, in_m, busy, owner} !== 9'b110000000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 110000000",
                     {rdy_0, rdy_1, out_0, out_1, read_m, write_m, in_m, busy, owner});
        end
        n_checks++;
        if (x_m !== 9'd0 || y_m !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_xy: got x=%0d y=%0d want 0 0", x_m, y_m);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_0();
        int base;
        bit to;
        mem_lat = 2;
        base = log_owner_q.size();
        req_0(1'b0, 1'b1, 9'd10, 8'd20, 1'b1);
        n_checks++;
        if (rdy_0 !== 1'b0) begin n_fail++; $display("FAIL wr_accept_rdy: got %b want 0", rdy_0); end
        x_0 = 9'd99; y_0 = 8'd99; in_0 = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({write_m, read_m, in_m, busy, owner} !== 5'b10110) begin
            n_fail++;
            $display("FAIL wr_issue: got w,r,in,busy,own=%b want 10110", {write_m, read_m, in_m, busy, owner});
        end
        n_checks++;
        if (x_m !== 9'd10 || y_m !== 8'd20) begin
            n_fail++;
            $display("FAIL wr_addr: got x=%0d y=%0d want 10 20", x_m, y_m);
        end
        @(negedge clk);
        n_checks++;
        if (write_m !== 1'b0 || rdy_0 !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_pulse_width: got write_m=%b rdy_0=%b want 0 0", write_m, rdy_0);
        end
        @(negedge clk);
        n_checks++;
        if (rdy_0 !== 1'b0) begin n_fail++; $display("FAIL wr_wait_rdy: got %b want 0", rdy_0); end
        @(negedge clk);
        n_checks++;
        if ({rdy_0, busy, owner} !== 3'b100) begin
            n_fail++;
            $display("FAIL wr_complete: got rdy,busy,own=%b want 100", {rdy_0, busy, owner});
        end
        n_checks++;
        if (log_owner_q.size() - base !== 1) begin
            n_fail++;
            $display("FAIL wr_count: got %0d accesses want 1", log_owner_q.size() - base);
        end
        wait_idle(20, to);
    endtask

    task automatic test_read_1();
        bit to;
        mem_lat = 0;
        mem_rdata = 1'b1;
        req_1(1'b1, 1'b0, 9'd5, 8'd5, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({read_m, write_m, owner} !== 3'b101 || x_m !== 9'd5 || y_m !== 8'd5) begin
            n_fail++;
            $display("FAIL rd1_issue: got r,w,own=%b x=%0d y=%0d want 101 5 5",
                     {read_m, write_m, owner}, x_m, y_m);
        end
        @(negedge clk);
        n_checks++;
        if (rdy_1 !== 1'b0 || read_m !== 1'b0) begin
            n_fail++;
            $display("FAIL rd1_early: got rdy_1=%b read_m=%b want 0 0", rdy_1, read_m);
        end
        @(negedge clk);
        n_checks++;
        if ({rdy_1, out_1, out_0, busy} !== 4'b1100) begin
            n_fail++;
            $display("FAIL rd1_complete: got rdy1,out1,out0,busy=%b want 1100", {rdy_1, out_1, out_0, busy});
        end
        wait_idle(20, to);
    endtask

    task automatic test_ignore();
        int base;
        bit to;
        mem_lat = 2;
        mem_rdata = 1'b1;
        base = log_owner_q.size();
        req_0(1'b1, 1'b0, 9'd3, 8'd4, 1'b0);
        req_0(1'b1, 1'b0, 9'd100, 8'd100, 1'b0);
        wait_idle(30, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL ign_timeout: got busy want idle"); end
        n_checks++;
        if (log_owner_q.size() - base !== 1 || log_x_q[log_x_q.size()-1] !== 9'd3) begin
            n_fail++;
            $display("FAIL ign_single: got %0d accesses last x=%0d want 1 3",
                     log_owner_q.size() - base, log_x_q[log_x_q.size()-1]);
        end
        n_checks++;
        if (out_0 !== 1'b1) begin n_fail++; $display("FAIL ign_out0: got %b want 1", out_0); end
        // read and write together: one write, read data untouched
        mem_rdata = 1'b0;
        @(negedge clk);
        base = log_owner_q.size();
        req_0(1'b1, 1'b1, 9'd11, 8'd12, 1'b1);
        wait_idle(30, to);
        n_checks++;
        if (log_wr_q.size() - base !== 1 || log_wr_q[log_wr_q.size()-1] !== 1'b1) begin
            n_fail++;
            $display("FAIL rw_as_write: got %0d accesses last wr=%b want 1 1",
                     log_wr_q.size() - base, log_wr_q[log_wr_q.size()-1]);
        end
        n_checks++;
        if (out_0 !== 1'b1) begin n_fail++; $display("FAIL rw_out0: got %b want 1", out_0); end
    endtask

    task automatic test_out_of_range();
        logic [8:0] oor_x[2];
        logic [7:0] oor_y[2];
        int  base;
        bit  to;
        oor_x[0] = 9'd320; oor_y[0] = 8'd0;
        oor_x[1] = 9'd0;   oor_y[1] = 8'd200;
        mem_lat = 0;
        for (int v = 0; v < 2; v++) begin
            mem_rdata = 1'b1;
            base = log_owner_q.size();
            @(negedge clk);
            req_0(1'b1, 1'b0, 9'd319, 8'd199, 1'b0);
            wait_idle(20, to);
            n_checks++;
            if (log_x_q.size() - base !== 1 || x_m !== 9'd319 || y_m !== 8'd199 || out_0 !== 1'b1) begin
                n_fail++;
                $display("FAIL edge_inrange[%0d]: got n=%0d x=%0d y=%0d out0=%b want 1 319 199 1",
                         v, log_x_q.size() - base, x_m, y_m, out_0);
            end
            base = log_owner_q.size();
            req_0(1'b1, 1'b0, oor_x[v], oor_y[v], 1'b0);
            n_checks++;
            if (rdy_0 !== 1'b0) begin n_fail++; $display("FAIL oor_accept[%0d]: got %b want 0", v, rdy_0); end
            @(negedge clk);
            n_checks++;
            if (rdy_0 !== 1'b1 || out_0 !== 1'b0) begin
                n_fail++;
                $display("FAIL oor_done[%0d]: got rdy0=%b out0=%b want 1 0", v, rdy_0, out_0);
            end
            repeat (3) @(negedge clk);
            n_checks++;
            if (log_owner_q.size() - base !== 0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL oor_noaccess[%0d]: got n=%0d busy=%b want 0 0", v, log_owner_q.size() - base, busy);
            end
        end
    endtask

    task automatic test_scan_run();
        int base;
        bit to, to0, to1;
        mem_lat = 1;
        mem_rec = 1;
        mem_rdata = 1'b1;
        to0 = 1'b0;
        to1 = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 10; i++) exp_q.push_back(((i % 5) == 4) ? 1'b0 : 1'b1);
        base = log_owner_q.size();
        @(negedge clk);
        fork
            begin
                for (int r = 0; r < 2; r++) begin
                    int k;
                    k = 0;
                    while (!rdy_0 && k < 200) begin @(negedge clk); k++; end
                    if (rdy_0) req_0(1'b0, 1'b1, 9'(40 + r), 8'd1, 1'b1);
                    else to0 = 1'b1;
                end
            end
            begin
                for (int r = 0; r < 8; r++) begin
                    int k;
                    k = 0;
                    while (!rdy_1 && k < 200) begin @(negedge clk); k++; end
                    if (rdy_1) req_1(1'b1, 1'b0, 9'(r), 8'(r), 1'b0);
                    else to1 = 1'b1;
                end
            end
        join
        wait_idle(200, to);
        n_checks++;
        if (to || to0 || to1) begin
            n_fail++;
            $display("FAIL scan_timeout: got to=%b%b%b want 000", to, to0, to1);
        end
        n_checks++;
        if (log_owner_q.size() - base !== exp_q.size()) begin
            n_fail++;
            $display("FAIL scan_count: got %0d grants want %0d", log_owner_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < log_owner_q.size()) begin
                n_checks++;
                if (log_owner_q[base + i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL scan_order[%0d]: got owner %b want %b", i, log_owner_q[base + i], exp_q[i]);
                end
            end
        end
        mem_rec = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int base;
        bit to;
        mem_lat = 5;
        mem_rdata = 1'b1;
        req_1(1'b1, 1'b0, 9'd7, 8'd7, 1'b0);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || rdy_1 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_pre: got busy=%b rdy1=%b want 1 0", busy, rdy_1);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({rdy_0, rdy_1, out_0, out_1, read_m, write_m, in_m, busy, owner} !== 9'b110000000
            || x_m !== 9'd0 || y_m !== 8'd0) begin
            n_fail++;
            $display("FAIL rst_async: got %b x=%0d y=%0d want 110000000 0 0",
                     {rdy_0, rdy_1, out_0, out_1, read_m, write_m, in_m, busy, owner}, x_m, y_m);
        end
        @(negedge clk);
        rst = 1'b0;
        mem_hold = 1'b1;
        mem_lat = 1;
        n_checks++;
        if (out_1 !== 1'b0 || rdy_1 !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_nocpl: got out1=%b rdy1=%b want 0 1", out_1, rdy_1);
        end
        base = log_owner_q.size();
        req_0(1'b0, 1'b1, 9'd21, 8'd22, 1'b1);
        repeat (4) @(negedge clk);
        n_checks++;
        if (log_owner_q.size() - base !== 0 || busy !== 1'b0 || rdy_0 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_hold: got n=%0d busy=%b rdy0=%b want 0 0 0",
                     log_owner_q.size() - base, busy, rdy_0);
        end
        mem_hold = 1'b0;
        wait_idle(50, to);
        n_checks++;
        if (to || log_owner_q.size() - base !== 1) begin
            n_fail++;
            $display("FAIL rst_after: got to=%b n=%0d want 0 1", to, log_owner_q.size() - base);
        end
        n_checks++;
        if (log_owner_q.size() > base && (log_owner_q[base] !== 1'b0 || log_x_q[base] !== 9'd21)) begin
            n_fail++;
            $display("FAIL rst_after_op: got owner=%b x=%0d want 0 21", log_owner_q[base], log_x_q[base]);
        end
    endtask

    // Main sequence
    initial begin
        test_reset();
        test_write_0();
        test_read_1();
        test_ignore();
        test_out_of_range();
        test_scan_run();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
